i2c_slave_regs: RTL and testbench

Synthesizable I2C target (slave) with a 16-byte register file, the bus-side counterpart of `i2c_master_top`. It attaches to the same open-drain SCL/SDA lines as the master and answers 7-bit-addressed write and read transfers. The byte pointer auto-increments, and every received data byte is exposed to local logic as a write strobe. It replaces behavioural slave models in system-level benches and ships as a peripheral.

---
 rtl/i2c_slave_regs.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// I2C target with a 2^ADDR_W byte register file, auto-incrementing pointer
// and a local write strobe for every received data byte.
module i2c_slave_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h2,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              wb_clk_i,
  input  logic              rst_ni,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  input  logic [ADDR_W-1:0] host_adr_i,
  output logic [7:0]        host_dat_o,
  output logic              wr_stb_o,
  output logic [ADDR_W-1:0] wr_adr_o,
  output logic [7:0]        wr_dat_o,
  output logic              busy_o
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_e;

  state_e            state_q, state_d;
  logic              scl_s1_q, scl_s2_q, scl_h_q;
  logic              sda_s1_q, sda_s2_q, sda_h_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              oen_q, oen_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              acked_q, acked_d;
  logic              stb_q, stb_d;
  logic [ADDR_W-1:0] wadr_q, wadr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic              we_c;
  logic [7:0]        regs_q [NREGS];

  logic              scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [7:0]        byte_c, rd_byte_c;
  logic [ADDR_W-1:0] ptr_inc_c;

  // Two-stage synchronizers plus one history stage; idle bus level is high
  always_ff @(posedge wb_clk_i) begin
    if (!rst_ni) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_pad_i; scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
      sda_s1_q <= sda_pad_i; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
    end
  end

  assign scl_rise_c = scl_s2_q & ~scl_h_q;
  assign scl_fall_c = ~scl_s2_q & scl_h_q;
  assign start_c    = scl_s2_q & ~sda_s2_q & sda_h_q;
  assign stop_c     = scl_s2_q & sda_s2_q & ~sda_h_q;
  assign byte_c     = {shift_q[6:0], sda_s2_q};
  assign rd_byte_c  = regs_q[ptr_q];
  assign ptr_inc_c  = ptr_q + ADDR_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath; bus conditions override bit processing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    oen_d   = oen_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    acked_d = acked_q;
    stb_d   = 1'b0;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    we_c    = 1'b0;
    if (start_c) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      oen_d   = 1'b1;
      acked_d = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
      acked_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise_c) begin
            shift_d = byte_c;
            cnt_d   = cnt_q + 3'(1);
            if (cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_c[7:1] == SLAVE_ADDR && byte_c[7:1] != 7'd0) begin
                  state_d = ADDR_ACK;
                  rw_d    = byte_c[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_d   = byte_c[ADDR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                we_c    = 1'b1;
                stb_d   = 1'b1;
                wadr_d  = ptr_q;
                wdat_d  = byte_c;
                ptr_d   = ptr_inc_c;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        // First SCL fall starts the ACK pulse, the second ends it
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall_c) begin
            if (oen_q) begin
              oen_d = 1'b0;
            end else begin
              oen_d = 1'b1;
              cnt_d = 3'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                shift_d = rd_byte_c;
                oen_d   = rd_byte_c[7];
                state_d = RDATA;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall_c) begin
            if (cnt_q == 3'd7) begin
              oen_d   = 1'b1;
              cnt_d   = 3'd0;
              state_d = RACK;
            end else begin
              oen_d   = shift_q[6];
              shift_d = {shift_q[6:0], 1'b1};
              cnt_d   = cnt_q + 3'(1);
            end
          end
        end
        // ACK seen on the rise; the next byte's MSB goes out on the following fall
        RACK: begin
          if (scl_rise_c) begin
            if (sda_s2_q) begin
              state_d = IGNORE;
            end else begin
              ptr_d   = ptr_inc_c;
              acked_d = 1'b1;
            end
          end else if (scl_fall_c && acked_q) begin
            acked_d = 1'b0;
            shift_d = rd_byte_c;
            oen_d   = rd_byte_c[7];
            cnt_d   = 3'd0;
            state_d = RDATA;
          end
        end
        default: begin
          oen_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      ptr_q   <= '0;
      oen_q   <= 1'b1;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      acked_q <= 1'b0;
      stb_q   <= 1'b0;
      wadr_q  <= '0;
      wdat_q  <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      oen_q   <= oen_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      acked_q <= acked_d;
      stb_q   <= stb_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else if (we_c) begin
      regs_q[ptr_q] <= byte_c;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign host_dat_o   = regs_q[host_adr_i];
  assign wr_stb_o     = stb_q;
  assign wr_adr_o     = wadr_q;
  assign wr_dat_o     = wdat_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master drives the
// open-drain bus and checks ACKs, read data, strobes and register contents.
module tb_i2c_slave_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_pad_o, sda_padoen_o;
  logic [3:0] host_adr;
  logic [7:0] host_dat;
  logic       wr_stb;
  logic [3:0] wr_adr;
  logic [7:0] wr_dat;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] stb_adr [$];
  logic [7:0] stb_dat [$];

  always #5 clk = ~clk;

  // Wired-AND open-drain SDA
  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_slave_regs #(.SLAVE_ADDR(7'h2), .ADDR_W(4)) dut (
    .wb_clk_i    (clk),
    .rst_ni      (rst_n),
    .scl_pad_i   (scl_m),
    .sda_pad_i   (sda_line),
    .sda_pad_o   (sda_pad_o),
    .sda_padoen_o(sda_padoen_o),
    .host_adr_i  (host_adr),
    .host_dat_o  (host_dat),
    .wr_stb_o    (wr_stb),
    .wr_adr_o    (wr_adr),
    .wr_dat_o    (wr_dat),
    .busy_o      (busy)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_adr.push_back(wr_adr);
      stb_dat.push_back(wr_dat);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reg(input string tag, input logic [3:0] adr, input logic [7:0] exp);
    host_adr = adr;
    clks(1);
    check(tag, 32'(host_dat), 32'(exp));
  endtask

  task automatic check_stb(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
    check({tag, "_present"}, 32'(stb_adr.size() > idx), 32'd1);
    if (stb_adr.size() > idx) begin
      check({tag, "_adr"}, 32'(stb_adr[idx]), 32'(a));
      check({tag, "_dat"}, 32'(stb_dat[idx]), 32'(d));
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(5);
    scl_m = 1'b1; clks(8);
    sda_m = 1'b0; clks(8);
    scl_m = 1'b0; clks(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(5);
    scl_m = 1'b1; clks(8);
    sda_m = 1'b1; clks(8);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; clks(5);
      scl_m = 1'b1; clks(8);
      scl_m = 1'b0; clks(5);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; clks(5);
    scl_m = 1'b1; clks(4);
    ack = sda_line; clks(4);
    scl_m = 1'b0; clks(5);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack_bit);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clks(5);
      scl_m = 1'b1; clks(4);
      b[i] = sda_line; clks(4);
      scl_m = 1'b0;
    end
    clks(4);
    sda_m = ack_bit; clks(4);
    scl_m = 1'b1; clks(8);
    scl_m = 1'b0; clks(4);
    sda_m = 1'b1; clks(1);
  endtask

  initial begin
    logic       ack, acks;
    logic [7:0] d0, d1, d2;
    logic [7:0] bad_addr [2];
    int         base;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; host_adr = 4'd0;
    clks(3);
    check("rst_oen", 32'(sda_padoen_o), 32'd1);
    check("rst_stb", 32'(wr_stb), 32'd0);
    check("rst_wadr", 32'(wr_adr), 32'd0);
    check("rst_wdat", 32'(wr_dat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    clks(5);
    check_reg("rst_reg0", 4'd0, 8'h00);
    check_reg("rst_reg15", 4'd15, 8'h00);

    // Basic write at pointer 3
    base = stb_adr.size();
    i2c_start();
    write_byte(8'h04, ack); check("t1_addr_ack", 32'(ack), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    write_byte(8'h03, ack); check("t1_ptr_ack", 32'(ack), 32'd0);
    write_byte(8'h42, ack); check("t1_d0_ack", 32'(ack), 32'd0);
    write_byte(8'h43, ack); check("t1_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_stb_cnt", 32'(stb_adr.size() - base), 32'd2);
    check_stb("t1_stb0", base, 4'd3, 8'h42);
    check_stb("t1_stb1", base + 1, 4'd4, 8'h43);
    check_reg("t1_reg4", 4'd4, 8'h43);
    check_reg("t1_reg3", 4'd3, 8'h42);

    // Pointer wrap-around
    base = stb_adr.size();
    i2c_start();
    write_byte(8'h04, ack); acks = ack;
    write_byte(8'h0F, ack); acks |= ack;
    write_byte(8'hAA, ack); acks |= ack;
    write_byte(8'hBB, ack); acks |= ack;
    i2c_stop();
    check("t2_acks", 32'(acks), 32'd0);
    check_stb("t2_stb0", base, 4'd15, 8'hAA);
    check_stb("t2_stb1", base + 1, 4'd0, 8'hBB);
    check_reg("t2_reg15", 4'd15, 8'hAA);
    check_reg("t2_reg0", 4'd0, 8'hBB);
    check("t2_ptr", 32'(dut.ptr_q), 32'd1);

    // Repeated-START read from pointer 14
    i2c_start();
    write_byte(8'h04, ack); write_byte(8'h0E, ack); write_byte(8'h5C, ack);
    i2c_stop();
    check_reg("t3_reg14", 4'd14, 8'h5C);
    base = stb_adr.size();
    i2c_start();
    write_byte(8'h04, ack); acks = ack;
    write_byte(8'h0E, ack); acks |= ack;
    i2c_start();
    write_byte(8'h05, ack); acks |= ack;
    check("t3_acks", 32'(acks), 32'd0);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b0);
    read_byte(d2, 1'b1);
    check("t3_rd0", 32'(d0), 32'h5C);
    check("t3_rd1", 32'(d1), 32'hAA);
    check("t3_rd2", 32'(d2), 32'hBB);
    check("t3_released", 32'(sda_padoen_o), 32'd1);
    i2c_stop();
    check("t3_busy_end", 32'(busy), 32'd0);
    check("t3_no_stb", 32'(stb_adr.size() - base), 32'd0);
    check("t3_ptr", 32'(dut.ptr_q), 32'd0);

    // Wrong address and general call are ignored
    bad_addr[0] = 8'h06;
    bad_addr[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      base = stb_adr.size();
      i2c_start();
      write_byte(bad_addr[k], ack);
      check($sformatf("t4_nack_%0h", bad_addr[k]), 32'(ack), 32'd1);
      check($sformatf("t4_busy_%0h", bad_addr[k]), 32'(busy), 32'd0);
      write_byte(8'h55, ack);
      check($sformatf("t4_dnack_%0h", bad_addr[k]), 32'(ack), 32'd1);
      i2c_stop();
      check($sformatf("t4_no_stb_%0h", bad_addr[k]), 32'(stb_adr.size() - base), 32'd0);
    end
    check_reg("t4_reg0", 4'd0, 8'hBB);

    // STOP after 5 bits of a data byte
    base = stb_adr.size();
    i2c_start();
    write_byte(8'h04, ack); acks = ack;
    write_byte(8'h05, ack); acks |= ack;
    send_bits(8'h9F, 5);
    i2c_stop();
    check("t5_acks", 32'(acks), 32'd0);
    check("t5_no_stb", 32'(stb_adr.size() - base), 32'd0);
    check_reg("t5_reg5", 4'd5, 8'h00);
    i2c_start();
    write_byte(8'h04, ack); acks = ack;
    write_byte(8'h07, ack); acks |= ack;
    write_byte(8'h31, ack); acks |= ack;
    i2c_stop();
    check("t5_next_acks", 32'(acks), 32'd0);
    check_stb("t5_stb", base, 4'd7, 8'h31);
    check_reg("t5_reg7", 4'd7, 8'h31);

    // Reset while the target drives a 0 read bit (regs[8] = 0)
    i2c_start();
    write_byte(8'h05, ack);
    check("t6_addr_ack", 32'(ack), 32'd0);
    check("t6_driving", 32'(sda_padoen_o), 32'd0);
    rst_n = 1'b0;
    clks(1);
    check("t6_oen_rst", 32'(sda_padoen_o), 32'd1);
    check("t6_busy_rst", 32'(busy), 32'd0);
    rst_n = 1'b1;
    check_reg("t6_reg7_clr", 4'd7, 8'h00);
    base = stb_adr.size();
    i2c_start();
    write_byte(8'h04, ack); acks = ack;
    write_byte(8'h02, ack); acks |= ack;
    write_byte(8'h7E, ack); acks |= ack;
    i2c_stop();
    check("t6_acks", 32'(acks), 32'd0);
    check_stb("t6_stb", base, 4'd2, 8'h7E);
    check_reg("t6_reg2", 4'd2, 8'h7E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
